// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle combinational ALU between two
// valid/ready requesters. Round-robin arbitration in IDLE, one operation in
// flight; the ALU result is registered at the request handshake and held on
// the owner's response channel until it is taken.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    // Requester 0 request channel
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    // Requester 1 request channel
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    // Requester 0 response channel
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,

    // Requester 1 response channel
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,

    // Shared ALU
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result
);

    typedef enum logic {
        IDLE = 1'b0,   // free: arbitrate and drive the ALU
        RESP = 1'b1    // result registered, waiting for the owner to take it
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             owner_q, owner_d;       // requester the held result belongs to
    logic             last_grant_q, last_grant_d;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             owner_rsp_ready;

    // Round-robin arbitration; grants only exist while IDLE, so a grant is
    // also the ready and therefore the handshake itself.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                // On a tie the requester that did not win last time goes next.
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign accept          = gnt0 | gnt1;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: capture the ALU result at the handshake, release on the owner's take.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d      = RESP;
                result_d     = alu_result;
                owner_d      = gnt1;
                last_grant_d = gnt1;
            end
        end else begin
            // No new request is accepted in the cycle the response is taken.
            if (owner_rsp_ready) begin
                state_d = IDLE;
            end
        end
    end

    // Outputs: readies and ALU drive from the grant, responses from the held result.
    always_comb begin
        req0_ready  = gnt0;
        req1_ready  = gnt1;

        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;
        if (gnt0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (gnt1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end

        rsp0_valid  = (state_q == RESP) && !owner_q;
        rsp1_valid  = (state_q == RESP) &&  owner_q;
        rsp0_result = result_q;
        rsp1_result = result_q;
    end

    // Structural invariants of the arbiter.
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));
    a_one_rsp: assert property (@(posedge clk) disable iff (rst)
        !(rsp0_valid && rsp1_valid));
    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (state_q == RESP && !owner_rsp_ready) |=> (state_q == RESP && $stable(result_q) && $stable(owner_q)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  c [2];
    logic        rr [2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Bench-side ALU: add, sub, and, or, xor, sll, srl; other opcodes return 0.
    function automatic logic [31:0] alu_ref(logic [31:0] x, logic [31:0] y, logic [3:0] op);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return x << y[4:0];
            4'd6:    return x >> y[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_ctrl);

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_ready (req0_ready),
        .req0_a     (a[0]),
        .req0_b     (b[0]),
        .req0_ctrl  (c[0]),
        .req1_valid (v[1]),
        .req1_ready (req1_ready),
        .req1_a     (a[1]),
        .req1_b     (b[1]),
        .req1_ctrl  (c[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rr[0]),
        .rsp0_result(rsp0_result),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rr[1]),
        .rsp1_result(rsp1_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: is an operation outstanding, whose, which result, who won last.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    logic [31:0] m_result;
    int          exp_gnt;
    bit          cap_rst;
    int          cap_gnt;
    logic [31:0] cap_res;
    bit          cap_rr [2];

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_last   = 1;
        m_result = 32'd0;
    endtask

    task automatic compare_model();
        int g;
        g = -1;
        if (!m_busy) begin
            if (v[0] && v[1]) g = (m_last == 0) ? 1 : 0;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        exp_gnt = g;
        check("m_req0_ready", req0_ready, g == 0);
        check("m_req1_ready", req1_ready, g == 1);
        check("m_alu_a",    alu_a,    (g >= 0) ? a[g] : 32'd0);
        check("m_alu_b",    alu_b,    (g >= 0) ? b[g] : 32'd0);
        check("m_alu_ctrl", alu_ctrl, (g >= 0) ? c[g] : 4'd0);
        check("m_rsp0_valid", rsp0_valid, m_busy && m_owner == 0);
        check("m_rsp1_valid", rsp1_valid, m_busy && m_owner == 1);
        if (m_busy) begin
            check("m_rsp0_result", rsp0_result, m_result);
            check("m_rsp1_result", rsp1_result, m_result);
        end
    endtask

    task automatic update_model();
        if (cap_rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (cap_gnt >= 0) begin
                m_busy   = 1'b1;
                m_owner  = cap_gnt;
                m_last   = cap_gnt;
                m_result = cap_res;
            end
        end else if (cap_rr[m_owner]) begin
            m_busy = 1'b0;
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic step();
        #1;
        compare_model();
        cap_rst   = rst;
        cap_gnt   = exp_gnt;
        cap_res   = (exp_gnt >= 0) ? alu_ref(a[exp_gnt], b[exp_gnt], c[exp_gnt]) : 32'd0;
        cap_rr[0] = rr[0];
        cap_rr[1] = rr[1];
        @(posedge clk);
        #1;
        update_model();
    endtask

    function automatic logic ready_of(int r);
        return (r == 0) ? req0_ready : req1_ready;
    endfunction

    // Issue one operation on requester r (response taken at once) and check its result.
    task automatic do_op(string tag, int r, logic [31:0] x, logic [31:0] y, logic [3:0] op,
                         logic [31:0] exp);
        v[r] = 1'b1; a[r] = x; b[r] = y; c[r] = op;
        rr[r] = 1'b1;
        #1;
        check({tag, "_ready"}, ready_of(r), 1'b1);
        step();
        v[r] = 1'b0;
        #1;
        check({tag, "_valid"}, (r == 0) ? rsp0_valid : rsp1_valid, 1'b1);
        check({tag, "_result"}, (r == 0) ? rsp0_result : rsp1_result, exp);
        step();
    endtask

    initial begin
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; a[r] = '0; b[r] = '0; c[r] = '0; rr[r] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        #1;
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp1_valid", rsp1_valid, 1'b0);
        check("rst_result",     rsp0_result, 32'd0);
        step();
        rst = 1'b0;

        // Single op: 5 + 3
        rr[0] = 1'b1; rr[1] = 1'b1;
        v[0] = 1'b1; a[0] = 32'd5; b[0] = 32'd3; c[0] = 4'd0;
        #1;
        check("single_ready0", req0_ready, 1'b1);
        check("single_ready1", req1_ready, 1'b0);
        check("single_alu_a",  alu_a, 32'd5);
        step();
        v[0] = 1'b0;
        #1;
        check("single_rsp0_valid", rsp0_valid, 1'b1);
        check("single_rsp0_result", rsp0_result, 32'd8);
        check("single_rsp1_valid", rsp1_valid, 1'b0);
        step();

        // Contention from reset: sub 10-4 on port 0, xor F0^FF on port 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        v[0] = 1'b1; a[0] = 32'd10;   b[0] = 32'd4;    c[0] = 4'd1;
        v[1] = 1'b1; a[1] = 32'hF0;   b[1] = 32'hFF;   c[1] = 4'd4;
        #1;
        check("cont_g1_ready0", req0_ready, 1'b1);
        check("cont_g1_ready1", req1_ready, 1'b0);
        step();
        a[0] = 32'd1; b[0] = 32'd1; c[0] = 4'd0;   // requester 0 has another op
        #1;
        check("cont_rsp0_valid",  rsp0_valid, 1'b1);
        check("cont_rsp0_result", rsp0_result, 32'd6);
        check("cont_resp_ready0", req0_ready, 1'b0);
        check("cont_resp_ready1", req1_ready, 1'b0);
        step();
        #1;
        check("cont_g2_ready1", req1_ready, 1'b1);
        check("cont_g2_ready0", req0_ready, 1'b0);
        step();
        v[1] = 1'b0;
        #1;
        check("cont_rsp1_valid",  rsp1_valid, 1'b1);
        check("cont_rsp1_result", rsp1_result, 32'h0F);
        step();
        #1;
        check("cont_g3_ready0", req0_ready, 1'b1);
        step();
        v[0] = 1'b0;
        step();

        // Backpressure: sll 1 << 5 on port 1, response held for 4 cycles
        v[1] = 1'b1; a[1] = 32'd1; b[1] = 32'h25; c[1] = 4'd5;
        rr[1] = 1'b0;
        #1;
        check("bp_ready1", req1_ready, 1'b1);
        step();
        v[1] = 1'b0;
        v[0] = 1'b1; a[0] = 32'd7; b[0] = 32'd7; c[0] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_hold_valid1",  rsp1_valid, 1'b1);
            check("bp_hold_result1", rsp1_result, 32'h20);
            check("bp_hold_ready0",  req0_ready, 1'b0);
            step();
        end
        rr[1] = 1'b1;
        #1;
        check("bp_take_valid1", rsp1_valid, 1'b1);
        check("bp_take_ready0", req0_ready, 1'b0);
        step();
        #1;
        check("bp_idle_valid1", rsp1_valid, 1'b0);
        check("bp_idle_ready0", req0_ready, 1'b1);
        step();
        v[0] = 1'b0;
        step();

        // Shift and edge operations
        do_op("srl31",   0, 32'h8000_0000, 32'd31, 4'd6, 32'd1);
        do_op("addwrap", 1, 32'hFFFF_FFFF, 32'd1,  4'd0, 32'd0);
        do_op("badop",   0, 32'h1234_5678, 32'h9,  4'hF, 32'd0);

        // Idle drive
        #1;
        check("idle_alu_a",    alu_a,    32'd0);
        check("idle_alu_b",    alu_b,    32'd0);
        check("idle_alu_ctrl", alu_ctrl, 4'd0);
        check("idle_ready0",   req0_ready, 1'b0);
        check("idle_ready1",   req1_ready, 1'b0);
        step();

        // Reset while a response is pending
        v[0] = 1'b1; a[0] = 32'd2; b[0] = 32'd3; c[0] = 4'd0;
        rr[0] = 1'b0;
        step();
        v[0] = 1'b0;
        #1;
        check("rmid_rsp0_valid", rsp0_valid, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rmid_rsp0_valid_after", rsp0_valid, 1'b0);
        check("rmid_rsp1_valid_after", rsp1_valid, 1'b0);
        check("rmid_ready0_after",     req0_ready, 1'b0);
        check("rmid_ready1_after",     req1_ready, 1'b0);
        check("rmid_result_after",     rsp0_result, 32'd0);
        step();
        v[0] = 1'b1; a[0] = 32'd4; b[0] = 32'd4; c[0] = 4'd2;
        v[1] = 1'b1; a[1] = 32'd9; b[1] = 32'd3; c[1] = 4'd1;
        rr[0] = 1'b1; rr[1] = 1'b1;
        #1;
        check("rmid_tie_ready0", req0_ready, 1'b1);
        check("rmid_tie_ready1", req1_ready, 1'b0);
        step();
        v[0] = 1'b0;

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 2) == 0) begin
                    v[r] = 1'b1;
                    a[r] = $urandom;
                    b[r] = $urandom;
                    c[r] = 4'($urandom_range(0, 15));
                end
                rr[r] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            for (int r = 0; r < 2; r++) begin
                if (exp_gnt == r) v[r] = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single-cycle combinational ALU between two requesters, e.g. the execute stage on port 0 and the address/branch unit on port 1. Each requester has a valid/ready request channel carrying operands and an ALU opcode, and a valid/ready response channel carrying the result. The block drives the ALU operand and control inputs, registers the ALU result, and returns it to the requester that issued the operation. Two-requester round-robin arbitration; one operation in flight.

Parameters:
WIDTH, 32, operand/result width (matches ALU datapath)
CTRL_W, 4, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_ctrl  in  CTRL_W  ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as port 0, for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp0_result  out  WIDTH  result for requester 0
rsp1_valid, rsp1_ready, rsp1_result  same as port 0, for requester 1
alu_a  out  WIDTH  to ALU operand A
alu_b  out  WIDTH  to ALU operand B
alu_ctrl  out  CTRL_W  to ALU opcode
alu_result  in  WIDTH  from ALU result

Behaviour:
- FSM states: IDLE and RESP. Reset state is IDLE.
- Reset values: state=IDLE; result_q=0; owner=0; last_grant=1, so requester 0 wins the first tie; all ready and rsp_valid outputs = 0.
- Arbitration (IDLE only, combinational):
  - Only one reqN_valid asserted -> grant that requester.
  - Both asserted -> grant the requester != last_grant.
  - Neither asserted -> no grant.
- Ready: reqN_ready = (state==IDLE) & grantN. Never asserted in RESP. Never asserted to both requesters in the same cycle.
- ALU drive:
  - IDLE with a grant -> alu_a/alu_b/alu_ctrl = the granted requester's fields, combinationally.
  - Otherwise -> all zero.
- Handshake (reqN_valid & reqN_ready) at edge N:
  - result_q <= alu_result; owner <= N; last_grant <= N; state -> RESP.
  - Result is visible on rspN_valid in cycle N+1.
- RESP state:
  - rsp[owner]_valid = 1; the other rsp_valid = 0.
  - Both rsp_result outputs = result_q.
  - Stay in RESP while rsp[owner]_ready = 0. result_q, owner and rsp_valid are held stable.
  - rsp[owner]_ready = 1 -> state -> IDLE next edge. No new request is accepted in that same cycle.
  - Minimum issue interval: 2 cycles per operation.
- Requesters hold valid and operands stable until ready. The block does not latch operands; they are sampled only through alu_result at the handshake edge.
- Opcodes are passed through unmodified. The ALU returns 0 for opcodes 4'b0111..4'b1111; the block treats that result as normal.
- rspN_ready while rspN_valid = 0 is ignored.
- Reset mid-operation: any pending response is dropped. All state returns to reset values on the next edge, and no rsp_valid is seen afterwards.
- A requester that keeps valid high with no competition is served every 2 cycles.
- Under continuous dual contention the grants alternate 0,1,0,1.

Test Plan:
- Single op: req0 a=5, b=3, ctrl=0000 -> req0_ready=1 in cycle 0; rsp0_valid=1, rsp0_result=8 in cycle 1; rsp1_valid stays 0.
- Contention: both valid from reset; req0 sub 10-4, req1 xor F0^FF -> results in grant order:
  - rsp0 = 6 first;
  - then rsp1 = 0x0F;
  - third grant goes to req0 if it is still valid.
- Backpressure: req1 sll a=1, b=0x25 (shift 5); hold rsp1_ready=0 for 4 cycles -> rsp1_valid stays 1 and rsp1_result stays 0x20; req0_ready stays 0 throughout; release -> IDLE next cycle.
- Shift/edge ops: srl a=0x80000000, b=31 -> 1; add 0xFFFFFFFF+1 -> 0 (wrap); invalid ctrl 1111 -> result 0 with a normal handshake.
- Reset mid-op: assert rst while in RESP with rsp0_valid=1 -> next cycle all valids and readies are 0 and result_q=0; afterwards the first tie is granted to req0.
- Idle drive: no requests -> alu_a, alu_b and alu_ctrl are all 0; no ready asserted.
